// File: rtl/gated_sr_latch_pkg.sv
// Shared definitions for the gated set/reset latch bank: the S=R=1 resolution
// policies and the next-state function used by the cell and the bench model.
package gated_sr_latch_pkg;

  typedef enum logic [1:0] {
    POL_RESET  = 2'd0,
    POL_SET    = 2'd1,
    POL_HOLD   = 2'd2,
    POL_TOGGLE = 2'd3
  } policy_t;

  // Next state of one enabled latch bit; the policy only matters when s and r are both high.
  function automatic logic next_q(input logic s, input logic r, input logic q,
                                  input logic [1:0] policy);
    logic nq;
    nq = q;
    unique case ({s, r})
      2'b00: nq = q;
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      2'b11: begin
        unique case (policy)
          POL_RESET:  nq = 1'b0;
          POL_SET:    nq = 1'b1;
          POL_HOLD:   nq = q;
          POL_TOGGLE: nq = ~q;
          default:    nq = 1'b0;
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/gated_sr_latch_cell.sv
// One clocked gated S/R latch bit with its registered S=R=1 flag.
// GATED_SR_LATCH_STICKY_INVALID_EN makes the flag hold until reset.
module gated_sr_cell
  import gated_sr_latch_pkg::*;
#(
  parameter logic [1:0] BOTH_POLICY = 2'd0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  input  logic en,
  output logic q,
  output logic invalid
);

  logic both;

  assign both = en & s & r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= 1'b0;
      invalid <= 1'b0;
    end else begin
      if (en) begin
        q <= next_q(s, r, q, BOTH_POLICY);
      end
`ifdef GATED_SR_LATCH_STICKY_INVALID_EN
      invalid <= invalid | both;
`else
      invalid <= both;
`endif
    end
  end

endmodule

// File: rtl/gated_sr_latch.sv
// Bank of WIDTH independent gated S/R latch bits sharing one enable.
// Optional build macro: GATED_SR_LATCH_STICKY_INVALID_EN (sticky invalid flags).
module gated_sr_latch
  import gated_sr_latch_pkg::*;
#(
  parameter int         WIDTH       = 1,
  parameter logic [1:0] BOTH_POLICY = 2'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] invalid
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    gated_sr_cell #(
      .BOTH_POLICY(BOTH_POLICY)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .s      (s[i]),
      .r      (r[i]),
      .en     (en),
      .q      (q[i]),
      .invalid(invalid[i])
    );
  end

  // qbar is derived from q only, so the two can never agree.
  assign qbar = ~q;

endmodule

// File: tb/tb_gated_sr_latch.sv
// Self-checking bench for gated_sr_latch: vector table for the 1-bit policy-0
// bank plus directed sequences for reset, policies, multi-bit and sticky flags.
module tb_gated_sr_latch;

`ifdef GATED_SR_LATCH_STICKY_INVALID_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       s1, r1, en;
  logic [3:0] s4, r4;
  logic [0:0] q0, qb0, inv0, q1, qb1, inv1, q2, qb2, inv2, q3, qb3, inv3;
  logic [3:0] q4, qb4, inv4;

  int checks   = 0;
  int failures = 0;

  gated_sr_latch #(.WIDTH(1), .BOTH_POLICY(2'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .en(en), .q(q0), .qbar(qb0), .invalid(inv0));
  gated_sr_latch #(.WIDTH(1), .BOTH_POLICY(2'd1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .en(en), .q(q1), .qbar(qb1), .invalid(inv1));
  gated_sr_latch #(.WIDTH(1), .BOTH_POLICY(2'd2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .en(en), .q(q2), .qbar(qb2), .invalid(inv2));
  gated_sr_latch #(.WIDTH(1), .BOTH_POLICY(2'd3)) dut3 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .en(en), .q(q3), .qbar(qb3), .invalid(inv3));
  gated_sr_latch #(.WIDTH(4), .BOTH_POLICY(2'd0)) dut4 (
    .clk(clk), .rst_n(rst_n), .s(s4), .r(r4), .en(en), .q(q4), .qbar(qb4), .invalid(inv4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic s;
    logic r;
    logic en;
    logic exp_q;
    logic exp_inv;
  } vec_t;

  vec_t vecs[10];

  task automatic apply_stimulus(input logic si, input logic ri, input logic eni);
    @(negedge clk);
    s1 = si;
    r1 = ri;
    en = eni;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    s1 = 1'b0; r1 = 1'b0; en = 1'b0;
    s4 = 4'b0; r4 = 4'b0;
    seen = 1'b0;

    // s, r, en, expected q, expected single-cycle invalid
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    #12;
    check_output("reset_q", {3'b0, q0}, 4'b0000);
    check_output("reset_qbar", {3'b0, qb0}, 4'b0001);
    check_output("reset_inv", {3'b0, inv0}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].s, vecs[i].r, vecs[i].en);
      if (vecs[i].s && vecs[i].r && vecs[i].en) seen = 1'b1;
      check_output($sformatf("vec%0d_q", i), {3'b0, q0}, {3'b0, vecs[i].exp_q});
      check_output($sformatf("vec%0d_qbar", i), {3'b0, qb0}, {3'b0, ~vecs[i].exp_q});
      check_output($sformatf("vec%0d_inv", i), {3'b0, inv0},
                   {3'b0, vecs[i].exp_inv | (STICKY & seen)});
    end

    // Asynchronous reset with set request active, checked before any edge
    @(negedge clk);
    s1 = 1'b1; r1 = 1'b0; en = 1'b1;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_q", {3'b0, q0}, 4'b0000);
    check_output("async_rst_qbar", {3'b0, qb0}, 4'b0001);
    check_output("async_rst_inv", {3'b0, inv0}, 4'b0000);
    @(posedge clk);
    #1;
    check_output("held_rst_q", {3'b0, q0}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Policy sweep from q=1
    apply_stimulus(1'b1, 1'b0, 1'b1);
    check_output("pol_pre", {q3, q2, q1, q0}, 4'b1111);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("pol_both1", {q3, q2, q1, q0}, 4'b0110);
    check_output("pol_qbar1", {qb3, qb2, qb1, qb0}, 4'b1001);
    check_output("pol_inv1", {inv3, inv2, inv1, inv0}, 4'b1111);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("pol_both2", {q3, q2, q1, q0}, 4'b1110);

    // Multi-bit bank from q=0
    @(negedge clk);
    s1 = 1'b0; r1 = 1'b0;
    s4 = 4'b0101; r4 = 4'b0011; en = 1'b1;
    @(posedge clk);
    #1;
    check_output("mb_q", q4, 4'b0100);
    check_output("mb_qbar", qb4, 4'b1011);
    check_output("mb_inv", inv4, 4'b0001);
    @(negedge clk);
    s4 = 4'b0; r4 = 4'b0;
    @(posedge clk);
    #1;
    check_output("mb_hold_q", q4, 4'b0100);
    check_output("mb_hold_inv", inv4, STICKY ? 4'b0001 : 4'b0000);

    // Invalid flag lifetime after one S=R=1 edge
    pulse_reset();
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("inv_set", {3'b0, inv0}, 4'b0001);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("inv_after_00", {3'b0, inv0}, {3'b0, STICKY});
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("inv_after_dis", {3'b0, inv0}, {3'b0, STICKY});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("inv_after_rst", {3'b0, inv0}, 4'b0000);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
